// File: rtl/gray_sweep_sequencer_if.sv
// Output stream of the Gray sweep sequencer: one (binary, Gray) pair per
// accepted valid/ready beat.
interface gray_sweep_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;

    modport master (
        output out_valid,
        output bin_out,
        output gray_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  bin_out,
        input  gray_out,
        output out_ready
    );
endinterface

// File: rtl/gray_sweep_sequencer.sv
// Walks bin_out from a latched first code to a latched last code (with wrap),
// emitting registered Gray codes and flagging any non-unit-distance Gray step.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; outputs quiet, count/adj_err hold last sweep
// ST_RUN  | presenting bin_out/gray_out, advancing on each accepted beat
// ST_DONE | one-cycle done pulse after the last beat, then back to idle
module gray_sweep_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       first,
    input  logic [WIDTH-1:0]       last,
    input  logic                   abort,
    gray_sweep_sequencer_if.master sif,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH:0]         count,
    output logic                   adj_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] prev_gray_q;
    logic [WIDTH:0]   count_q;
    logic             adj_err_q;

    logic             xfer;
    logic             at_last;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] gray_diff;
    logic             step_ok;

    assign xfer      = (state_q == ST_RUN) && sif.out_ready;
    assign at_last   = (bin_q == last_q);
    assign bin_inc   = bin_q + BIN_ONE;
    assign gray_diff = gray_q ^ prev_gray_q;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign step_ok   = (gray_diff != '0) && ((gray_diff & (gray_diff - BIN_ONE)) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort outranks the last-beat exit so no done pulse follows it
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (xfer && at_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= '0;
            bin_q       <= '0;
            gray_q      <= '0;
            prev_gray_q <= '0;
            count_q     <= '0;
            adj_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        last_q    <= last;
                        bin_q     <= first;
                        gray_q    <= first ^ (first >> 1);
                        count_q   <= '0;
                        adj_err_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        count_q     <= count_q + CNT_ONE;
                        prev_gray_q <= gray_q;
                        // The first beat of a sweep has no predecessor to compare with.
                        if ((count_q != '0) && !step_ok) begin
                            adj_err_q <= 1'b1;
                        end
                        if (!at_last) begin
                            bin_q  <= bin_inc;
                            gray_q <= bin_inc ^ (bin_inc >> 1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sif.out_valid = (state_q == ST_RUN);
    assign sif.bin_out   = bin_q;
    assign sif.gray_out  = gray_q;
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign count         = count_q;
    assign adj_err       = adj_err_q;

endmodule

// File: tb/tb_gray_sweep_sequencer.sv
// Directed bench for gray_sweep_sequencer: expected beats are queued when a
// sweep is launched and checked against accepted beats by a negedge monitor.
module tb_gray_sweep_sequencer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] first;
    logic [W-1:0] last;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W:0]   count;
    logic         adj_err;

    gray_sweep_sequencer_if #(.WIDTH(W)) sif ();

    gray_sweep_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .first   (first),
        .last    (last),
        .abort   (abort),
        .sif     (sif),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .adj_err (adj_err)
    );

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] sb[$];
    int gseq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    logic         hold_pending = 1'b0;
    logic [W-1:0] hold_bin;
    logic [W-1:0] hold_gray;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input int g);
        logic [W-1:0] bb;
        logic [W-1:0] gg;
        bb = b[W-1:0];
        gg = g[W-1:0];
        sb.push_back({bb, gg});
    endtask

    // Beats are judged at negedge, half a cycle before the edge that accepts them.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && sif.out_valid) begin
                check("hold_pair", {sif.bin_out, sif.gray_out}, {hold_bin, hold_gray});
            end
            hold_pending = sif.out_valid && !sif.out_ready;
            hold_bin     = sif.bin_out;
            hold_gray    = sif.gray_out;
            if (sif.out_valid && sif.out_ready) begin
                check("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("beat_pair", {sif.bin_out, sif.gray_out}, sb.pop_front());
                end
            end
        end
    end

    // mode 0: ready always; mode 1: ready on every third cycle plus a stray start
    task automatic run(input int f, input int l, input int mode, input logic with_abort,
                       input int exp_cnt, input int exp_cycles, input string tag);
        int  k;
        bit  seen;
        first = f[W-1:0];
        last  = l[W-1:0];
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        k     = 0;
        seen  = 0;
        while (k < 200 && !seen) begin
            sif.out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            if (mode == 1 && k == 1) begin
                start = 1'b1;
                first = '0;
                last  = '0;
            end
            tick();
            start = 1'b0;
            k++;
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_cycles"}, k, exp_cycles);
        check({tag, "_count"}, count, exp_cnt);
        check({tag, "_adj_err"}, adj_err, 0);
        check({tag, "_busy_in_done"}, busy, 0);
        check({tag, "_valid_in_done"}, sif.out_valid, 0);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_count_retained"}, count, exp_cnt);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        first         = '0;
        last          = '0;
        sif.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", sif.out_valid, 0);
        check("rst_bin", sif.bin_out, 0);
        check("rst_gray", sif.gray_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_adj_err", adj_err, 0);
        rst_n = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_no_effect", sif.out_valid, 0);

        for (int i = 0; i < 16; i++) push(i, gseq[i]);
        run(0, 15, 0, 1'b0, 16, 16, "full");

        push(3, 4'b0010); push(4, 4'b0110); push(5, 4'b0111); push(6, 4'b0101);
        run(3, 6, 1, 1'b0, 4, 10, "bp");

        push(14, 4'b1001); push(15, 4'b1000); push(0, 4'b0000); push(1, 4'b0001);
        run(14, 1, 0, 1'b0, 4, 4, "wrap");

        push(5, 4'b0111);
        run(5, 5, 0, 1'b1, 1, 1, "single");

        // Abort lands on the edge that accepts the third beat.
        push(0, 0); push(1, 1); push(2, 3);
        first = 4'd0; last = 4'd15; start = 1'b1; sif.out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", sif.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_count", count, 3);
        tick();
        check("abort_no_done_late", done, 0);
        check("abort_sb_empty", sb.size(), 0);
        push(8, 4'b1100); push(9, 4'b1101);
        run(8, 9, 0, 1'b0, 2, 2, "after_abort");

        for (int i = 0; i < 8; i++) push(i, gseq[i]);
        first = 4'd0; last = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (sif.bin_out !== 4'd7 && n < 40) begin
            tick();
            n++;
        end
        check("reach_bin7", sif.bin_out, 7);
        rst_n = 1'b0;
        start = 1'b1;
        first = 4'd2;
        tick();
        check("midrst_valid", sif.out_valid, 0);
        check("midrst_bin", sif.bin_out, 0);
        check("midrst_gray", sif.gray_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_count", count, 0);
        check("midrst_adj_err", adj_err, 0);
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        sb.delete();
        tick();
        check("start_ignored_in_reset", sif.out_valid, 0);
        push(10, 4'b1111); push(11, 4'b1110); push(12, 4'b1010);
        run(10, 12, 0, 1'b0, 3, 3, "fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
